// File: rtl/inst_axi_rd_bridge_if.sv
// AXI read-channel bundle (AR + R) between the instruction bridge and the SoC interconnect.
interface inst_axi_rd_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Instruction fetch sram-like port to single-beat AXI reads with kseg0/kseg1 translation.
// Optional macro IBRIDGE_RDATA_REG_EN registers data_ok/rdata (one cycle later, rdata held).
module inst_axi_rd_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] AR_ID           = 4'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inst_sram_en,
  input  logic                 inst_sram_wr,
  input  logic [1:0]           inst_sram_size,
  input  logic [3:0]           inst_sram_wen,
  input  logic [31:0]          inst_sram_addr,
  input  logic [31:0]          inst_sram_wdata,
  output logic                 inst_sram_addr_ok,
  output logic [31:0]          inst_sram_addr_ok_addr,
  output logic                 inst_sram_data_ok,
  output logic [31:0]          inst_sram_rdata,
  inst_axi_rd_bridge_if.master axi
);

  typedef enum logic {IDLE, AR} state_t;

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic [31:0] req_vaddr;
  logic [1:0]  req_size;
  logic        r_hs;
  logic        ar_hs;
  logic        accept;

  // Write-side and response-tag inputs are intentionally unused.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wen, inst_sram_wdata,
                           axi.rid, axi.rresp, axi.rlast};

  assign axi.rready = 1'b1;
  assign r_hs       = axi.rvalid && axi.rready;
  assign ar_hs      = (state == AR) && axi.arready;
  // A returning beat frees a slot in the same cycle, so it may admit a new request.
  assign accept     = (state == IDLE) && inst_sram_en && ((cnt < MAX_CNT) || r_hs);

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = AR;
      AR:   if (ar_hs)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_vaddr <= 32'h0;
      req_size  <= 2'b00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_vaddr <= inst_sram_addr;
        req_size  <= inst_sram_size;
      end
    end
  end

  // Outstanding count: simultaneous AR and R handshakes cancel; an R beat at zero does not wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 2'd0;
    end else begin
      unique case ({ar_hs, r_hs})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   if (cnt != 2'd0) cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign axi.arvalid = (state == AR);
  assign axi.araddr  = (req_vaddr[31:30] == 2'b10) ? {3'b000, req_vaddr[28:0]} : req_vaddr;
  assign axi.arsize  = {1'b0, req_size};
  assign axi.arid    = AR_ID;
  assign axi.arlen   = 8'd0;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;

  assign inst_sram_addr_ok      = ar_hs;
  assign inst_sram_addr_ok_addr = req_vaddr;

`ifdef IBRIDGE_RDATA_REG_EN
  logic        data_ok_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      data_ok_q <= r_hs;
      if (r_hs) rdata_q <= axi.rdata;
    end
  end

  assign inst_sram_data_ok = data_ok_q;
  assign inst_sram_rdata   = rdata_q;
`else
  assign inst_sram_data_ok = r_hs;
  assign inst_sram_rdata   = axi.rdata;
`endif

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge: translation, AR hold, outstanding limit, R/AR overlap, reset.
module tb_inst_axi_rd_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic [31:0] inst_sram_addr_ok_addr;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  inst_axi_rd_bridge_if axi_bus ();

  inst_axi_rd_bridge dut (
    .clk                    (clk),
    .reset                  (reset),
    .inst_sram_en           (inst_sram_en),
    .inst_sram_wr           (inst_sram_wr),
    .inst_sram_size         (inst_sram_size),
    .inst_sram_wen          (inst_sram_wen),
    .inst_sram_addr         (inst_sram_addr),
    .inst_sram_wdata        (inst_sram_wdata),
    .inst_sram_addr_ok      (inst_sram_addr_ok),
    .inst_sram_addr_ok_addr (inst_sram_addr_ok_addr),
    .inst_sram_data_ok      (inst_sram_data_ok),
    .inst_sram_rdata        (inst_sram_rdata),
    .axi                    (axi_bus)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled 2ns later, far from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // One R beat; data_ok is expected in the beat cycle, or the cycle after when registered.
  task automatic r_beat(input logic [31:0] d);
    axi_bus.rvalid = 1'b1;
    axi_bus.rdata  = d;
    settle();
`ifndef IBRIDGE_RDATA_REG_EN
    if (inst_sram_data_ok !== 1'b1) begin n_err++; $display("FAIL beat_data_ok: got %b want 1", inst_sram_data_ok); end
    n_cmp++;
    if (inst_sram_rdata !== d) begin n_err++; $display("FAIL beat_rdata: got %h want %h", inst_sram_rdata, d); end
    n_cmp++;
`endif
    tick();
    axi_bus.rvalid = 1'b0;
    axi_bus.rdata  = 32'h0;
    settle();
`ifdef IBRIDGE_RDATA_REG_EN
    if (inst_sram_data_ok !== 1'b1) begin n_err++; $display("FAIL beat_data_ok_reg: got %b want 1", inst_sram_data_ok); end
    n_cmp++;
    if (inst_sram_rdata !== d) begin n_err++; $display("FAIL beat_rdata_reg: got %h want %h", inst_sram_rdata, d); end
    n_cmp++;
    tick();
    settle();
`endif
    if (inst_sram_data_ok !== 1'b0) begin n_err++; $display("FAIL beat_data_ok_drop: got %b want 0", inst_sram_data_ok); end
    n_cmp++;
  endtask

  // Accept + immediate AR handshake; checks translation and the addr_ok tag.
  task automatic issue(input logic [31:0] va, input logic [31:0] pa);
    inst_sram_en   = 1'b1;
    inst_sram_addr = va;
    axi_bus.arready = 1'b1;
    settle();
    if (axi_bus.arvalid !== 1'b0) begin n_err++; $display("FAIL issue_arvalid_early: got %b want 0", axi_bus.arvalid); end
    n_cmp++;
    tick();
    settle();
    if ({axi_bus.arvalid, inst_sram_addr_ok} !== 2'b11) begin
      n_err++; $display("FAIL issue_handshake: got arvalid/addr_ok %b want 11", {axi_bus.arvalid, inst_sram_addr_ok});
    end
    n_cmp++;
    if (axi_bus.araddr !== pa) begin n_err++; $display("FAIL issue_araddr %h: got %h want %h", va, axi_bus.araddr, pa); end
    n_cmp++;
    if (inst_sram_addr_ok_addr !== va) begin n_err++; $display("FAIL issue_addr_ok_addr: got %h want %h", inst_sram_addr_ok_addr, va); end
    n_cmp++;
    tick();
    inst_sram_en    = 1'b0;
    axi_bus.arready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inst_sram_en = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'b10; inst_sram_wen = 4'h0;
    inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
    axi_bus.arready = 1'b0; axi_bus.rid = 4'h0; axi_bus.rdata = 32'h0;
    axi_bus.rresp = 2'b00; axi_bus.rlast = 1'b1; axi_bus.rvalid = 1'b0;
    tick(); tick();
    settle();
    if ({axi_bus.arvalid, inst_sram_addr_ok, inst_sram_data_ok} !== 3'b000) begin
      n_err++; $display("FAIL reset_pulses: got %b want 000", {axi_bus.arvalid, inst_sram_addr_ok, inst_sram_data_ok});
    end
    n_cmp++;
    if (inst_sram_addr_ok_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr_ok_addr: got %h want 0", inst_sram_addr_ok_addr); end
    n_cmp++;
    if (inst_sram_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", inst_sram_rdata); end
    n_cmp++;
    if (axi_bus.rready !== 1'b1) begin n_err++; $display("FAIL reset_rready: got %b want 1", axi_bus.rready); end
    n_cmp++;
    if (dut.cnt !== 2'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt); end
    n_cmp++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_kseg_first();
    issue(32'hbfc00000, 32'h1fc00000);
    settle();
    if ({axi_bus.arid, axi_bus.arlen, axi_bus.arsize, axi_bus.arburst} !== {4'd0, 8'd0, 3'b010, 2'b01}) begin
      n_err++; $display("FAIL ar_constants: got id %h len %h size %b burst %b", axi_bus.arid, axi_bus.arlen, axi_bus.arsize, axi_bus.arburst);
    end
    n_cmp++;
    if ({axi_bus.arlock, axi_bus.arcache, axi_bus.arprot} !== 9'd0) begin
      n_err++; $display("FAIL ar_attrs: got %h want 0", {axi_bus.arlock, axi_bus.arcache, axi_bus.arprot});
    end
    n_cmp++;
    if (dut.cnt !== 2'd1) begin n_err++; $display("FAIL kseg_cnt: got %0d want 1", dut.cnt); end
    n_cmp++;
    r_beat(32'h3c1dbfc0);
  endtask

  task automatic test_ar_hold();
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'hbfc00004;
    tick();
    inst_sram_addr = 32'hbfc00380;
    for (int i = 0; i < 3; i++) begin
      settle();
      if ({axi_bus.arvalid, inst_sram_addr_ok} !== 2'b10) begin
        n_err++; $display("FAIL hold_wait_%0d: got arvalid/addr_ok %b want 10", i, {axi_bus.arvalid, inst_sram_addr_ok});
      end
      n_cmp++;
      if (axi_bus.araddr !== 32'h1fc00004) begin n_err++; $display("FAIL hold_araddr_%0d: got %h want 1fc00004", i, axi_bus.araddr); end
      n_cmp++;
      tick();
    end
    axi_bus.arready = 1'b1;
    settle();
    if (inst_sram_addr_ok !== 1'b1) begin n_err++; $display("FAIL hold_addr_ok: got %b want 1", inst_sram_addr_ok); end
    n_cmp++;
    if (axi_bus.araddr !== 32'h1fc00004) begin n_err++; $display("FAIL hold_araddr_hs: got %h want 1fc00004", axi_bus.araddr); end
    n_cmp++;
    if (inst_sram_addr_ok_addr !== 32'hbfc00004) begin n_err++; $display("FAIL hold_addr_ok_addr: got %h want bfc00004", inst_sram_addr_ok_addr); end
    n_cmp++;
    tick();
    inst_sram_en    = 1'b0;
    axi_bus.arready = 1'b0;
    r_beat(32'h00000000);
  endtask

  task automatic test_outstanding_limit();
    issue(32'hbfc00010, 32'h1fc00010);
    issue(32'hbfc00014, 32'h1fc00014);
    if (dut.cnt !== 2'd2) begin n_err++; $display("FAIL limit_cnt_full: got %0d want 2", dut.cnt); end
    n_cmp++;
    inst_sram_en    = 1'b1;
    inst_sram_addr  = 32'hbfc00018;
    axi_bus.arready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      settle();
      if ({axi_bus.arvalid, inst_sram_addr_ok} !== 2'b00) begin
        n_err++; $display("FAIL limit_blocked_%0d: got arvalid/addr_ok %b want 00", i, {axi_bus.arvalid, inst_sram_addr_ok});
      end
      n_cmp++;
    end
    axi_bus.rvalid = 1'b1;
    axi_bus.rdata  = 32'h24010001;
    settle();
`ifndef IBRIDGE_RDATA_REG_EN
    if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, 32'h24010001}) begin
      n_err++; $display("FAIL limit_data_ok: got %b/%h want 1/24010001", inst_sram_data_ok, inst_sram_rdata);
    end
    n_cmp++;
`endif
    tick();
    axi_bus.rvalid = 1'b0;
    axi_bus.rdata  = 32'h0;
    settle();
`ifdef IBRIDGE_RDATA_REG_EN
    if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, 32'h24010001}) begin
      n_err++; $display("FAIL limit_data_ok_reg: got %b/%h want 1/24010001", inst_sram_data_ok, inst_sram_rdata);
    end
    n_cmp++;
`endif
    if ({axi_bus.arvalid, inst_sram_addr_ok} !== 2'b11) begin
      n_err++; $display("FAIL limit_third_accept: got arvalid/addr_ok %b want 11", {axi_bus.arvalid, inst_sram_addr_ok});
    end
    n_cmp++;
    if (inst_sram_addr_ok_addr !== 32'hbfc00018) begin n_err++; $display("FAIL limit_third_addr: got %h want bfc00018", inst_sram_addr_ok_addr); end
    n_cmp++;
    tick();
    inst_sram_en    = 1'b0;
    axi_bus.arready = 1'b0;
    settle();
    if (dut.cnt !== 2'd2) begin n_err++; $display("FAIL limit_cnt_after: got %0d want 2", dut.cnt); end
    n_cmp++;
    r_beat(32'h11111111);
    r_beat(32'h22222222);
  endtask

  task automatic test_overlap();
    issue(32'h9fc00020, 32'h1fc00020);
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h9fc00024;
    tick();
    axi_bus.arready = 1'b1;
    axi_bus.rvalid  = 1'b1;
    axi_bus.rdata   = 32'h8c020004;
    settle();
`ifdef IBRIDGE_RDATA_REG_EN
    if ({inst_sram_addr_ok, inst_sram_data_ok} !== 2'b10) begin
      n_err++; $display("FAIL overlap_pulses: got addr_ok/data_ok %b want 10", {inst_sram_addr_ok, inst_sram_data_ok});
    end
`else
    if ({inst_sram_addr_ok, inst_sram_data_ok} !== 2'b11) begin
      n_err++; $display("FAIL overlap_pulses: got addr_ok/data_ok %b want 11", {inst_sram_addr_ok, inst_sram_data_ok});
    end
`endif
    n_cmp++;
    tick();
    inst_sram_en    = 1'b0;
    axi_bus.arready = 1'b0;
    axi_bus.rvalid  = 1'b0;
    settle();
    if (dut.cnt !== 2'd1) begin n_err++; $display("FAIL overlap_cnt: got %0d want 1", dut.cnt); end
    n_cmp++;
`ifdef IBRIDGE_RDATA_REG_EN
    if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, 32'h8c020004}) begin
      n_err++; $display("FAIL overlap_data_reg: got %b/%h want 1/8c020004", inst_sram_data_ok, inst_sram_rdata);
    end
    n_cmp++;
    tick();
`endif
    r_beat(32'h8c020008);
  endtask

  task automatic test_translation();
    logic [31:0] va_tab [4];
    logic [31:0] pa_tab [4];
    va_tab = '{32'h00400000, 32'h80001234, 32'hc0000100, 32'h7ffffffc};
    pa_tab = '{32'h00400000, 32'h00001234, 32'hc0000100, 32'h7ffffffc};
    for (int i = 0; i < 4; i++) begin
      issue(va_tab[i], pa_tab[i]);
      r_beat(32'h1000 + 32'(i));
    end
  endtask

  task automatic test_underflow();
    r_beat(32'hdeadbeef);
    if (dut.cnt !== 2'd0) begin n_err++; $display("FAIL underflow_cnt: got %0d want 0", dut.cnt); end
    n_cmp++;
  endtask

  task automatic test_reset_in_ar();
    issue(32'hbfc00030, 32'h1fc00030);
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'hbfc00034;
    tick();
    settle();
    if (axi_bus.arvalid !== 1'b1) begin n_err++; $display("FAIL rst_ar_entered: got %b want 1", axi_bus.arvalid); end
    n_cmp++;
    reset = 1'b1;
    inst_sram_en = 1'b0;
    tick();
    settle();
    if (axi_bus.arvalid !== 1'b0) begin n_err++; $display("FAIL rst_ar_arvalid: got %b want 0", axi_bus.arvalid); end
    n_cmp++;
    if (dut.cnt !== 2'd0) begin n_err++; $display("FAIL rst_ar_cnt: got %0d want 0", dut.cnt); end
    n_cmp++;
    if (inst_sram_addr_ok_addr !== 32'h0) begin n_err++; $display("FAIL rst_ar_addr_ok_addr: got %h want 0", inst_sram_addr_ok_addr); end
    n_cmp++;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_kseg_first();
    test_ar_hold();
    test_outstanding_limit();
    test_overlap();
    test_translation();
    test_underflow();
    test_reset_in_ar();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
